// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: synchronised, oversampled 8N1 UART receiver with one-entry valid/ready holding register; `define UART_RX_PARITY_EN adds a parity bit (sense set by PARITY_ODD)
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W = 9,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o,
  output logic       busy_o
);
  localparam int H = CLKS_PER_BIT / 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic s1, rxs, last, deliver, ok;
  logic [CNT_W-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  assign busy_o = state != IDLE;
  // next state: mid-start check, then one sample per bit period
  always_comb begin
    last = cnt == ((state == START) ? CNT_W'(H - 1) : CNT_W'(CLKS_PER_BIT - 1));
    state_n = state;
    case (state)
      IDLE:      if (!rxs) state_n = START;
      START:     if (last) state_n = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:      if (last && &idx) state_n = PARITY;
      PARITY:    if (last) state_n = STOP;
`else
      DATA:      if (last && &idx) state_n = STOP;
`endif
      STOP:      if (last) state_n = rxs ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rxs) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    deliver = state == STOP && last && rxs && ok;
  end
`ifdef UART_RX_PARITY_EN
  logic bad, perr, perr_q;
  assign perr = (^sh ^ rxs) != 1'(PARITY_ODD);
  assign ok = !bad;
  assign parity_err_o = perr_q;
  // parity result: pulse on mismatch and remember it to suppress delivery
  always_ff @(posedge clk) begin
    if (rst) begin
      bad <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      perr_q <= state == PARITY && last && perr;
      if (state == START) bad <= 1'b0;
      else if (state == PARITY && last) bad <= perr;
    end
  end
`else
  assign ok = 1'b1;
  assign parity_err_o = PARITY_ODD < 0;
`endif
  // synchroniser, bit timing, deframing and holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      rxs <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      data_o <= '0;
      valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      s1 <= rx_i;
      rxs <= s1;
      state <= state_n;
      cnt <= (state == IDLE || state == WAIT_IDLE || last) ? '0 : cnt + 1'b1;
      if (state == START) idx <= '0;
      else if (state == DATA && last) begin
        sh <= {rxs, sh[7:1]};
        idx <= idx + 1'b1;
      end
      frame_err_o <= state == STOP && last && !rxs;
      if (deliver && !(valid_o && !ready_i)) begin
        data_o <= sh;
        valid_o <= 1'b1;
      end else if (deliver) overrun_o <= 1'b1;
      else if (ready_i) valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: scoreboard bench driving UART frames and checking delivered bytes and error pulses
module tb_uart_rx_frontend;
  localparam int C = 8;
  localparam int H = C / 2;
  localparam int PODD = 0;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, ready = 1'b1;
  logic [7:0] data;
  logic valid, frame_err, parity_err, overrun, busy;
  int errs = 0, checks = 0;
  int fe_seen = 0, fe_exp = 0, pe_seen = 0, pe_exp = 0;
  bit rand_rdy = 1'b0;
  logic [7:0] q[$];
  always #5 clk = ~clk;
  uart_rx_frontend #(.CLKS_PER_BIT(C), .CNT_W(4), .PARITY_ODD(PODD)) dut (
    .clk(clk), .rst(rst), .rx_i(rx), .data_o(data), .valid_o(valid), .ready_i(ready),
    .frame_err_o(frame_err), .parity_err_o(parity_err), .overrun_o(overrun), .busy_o(busy)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bits(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      tick(C);
    end
  endtask
  // one frame on the line; the line is left at the stop-bit level
  task automatic frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input bit push);
    logic [11:0] f;
    int n;
`ifdef UART_RX_PARITY_EN
    f = {1'b0, stop_ok, ^b ^ 1'(PODD) ^ !par_ok, b, 1'b0};
    n = 11;
`else
    f = {2'b00, stop_ok, b, 1'b0};
    n = 10;
`endif
    if (push && stop_ok && par_ok) q.push_back(b);
    if (!stop_ok) fe_exp++;
    if (!par_ok) pe_exp++;
    send_bits(f, n);
  endtask
  // random consumer readiness when enabled
  initial forever begin
    @(negedge clk);
    if (rand_rdy) ready = 1'($urandom_range(0, 1));
  end
  // monitor: count error pulses, pop and compare every handshake
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (frame_err) fe_seen++;
      if (parity_err) pe_seen++;
      if (valid && ready) begin
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", data);
        end else chk("byte", data, q.pop_front());
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat;
    logic [7:0] b;
    bit s, p;
    tick(3);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick(5);
    lat = -1;
    fork
      frame(8'hA5, 1'b1, 1'b1, 1'b1);
      begin
        for (int i = 1; i <= 200 && lat < 0; i++) begin
          @(negedge clk);
          if (valid) lat = i;
        end
        chk("latency", lat, 3 + H + 9 * C);
        @(negedge clk);
        chk("valid_one_cycle", valid, 0);
      end
    join
    tick(2);
    chk("a5_no_frame_err", fe_seen, 0);
    tick(3);
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(2);
    chk("glitch_busy_rise", busy, 1);
    tick(4);
    chk("glitch_busy_fall", busy, 0);
    chk("glitch_no_frame_err", fe_seen, fe_exp);
    tick(3);
    frame(8'h3C, 1'b0, 1'b1, 1'b1);
    tick(40);
    chk("break_busy_held", busy, 1);
    chk("break_one_frame_err", fe_seen, 1);
    rx = 1'b1;
    tick(4);
    chk("break_busy_release", busy, 0);
    tick(3);
    ready = 1'b0;
    frame(8'h11, 1'b1, 1'b1, 1'b1);
    tick(2);
    frame(8'h22, 1'b1, 1'b1, 1'b0);
    tick(4);
    chk("ovr_valid", valid, 1);
    chk("ovr_data_kept", data, 8'h11);
    chk("ovr_flag", overrun, 1);
    ready = 1'b1;
    tick(1);
    chk("ovr_handshake_clears", valid, 0);
    tick(5);
    chk("ovr_sticky", overrun, 1);
    send_bits({2'b00, 1'b1, 8'h55, 1'b0}, 5);
    rx = 1'b1;
    tick(H);
    rst = 1'b1;
    tick(2);
    chk("midrst_data", data, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_frame_err", frame_err, 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    frame(8'h0F, 1'b1, 1'b1, 1'b1);
    tick(4);
    chk("post_rst_delivered", q.size(), 0);
`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b1, 1'b1, 1'b1);
    tick(3);
    frame(8'h07, 1'b1, 1'b0, 1'b1);
    tick(4);
    chk("parity_err_pulse", pe_seen, pe_exp);
`endif
    rand_rdy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom);
      s = $urandom_range(0, 4) != 0;
`ifdef UART_RX_PARITY_EN
      p = $urandom_range(0, 3) != 0;
`else
      p = 1'b1;
`endif
      frame(b, s, p, 1'b1);
      if (!s) tick($urandom_range(1, 10));
      rx = 1'b1;
      tick($urandom_range(1, 6));
    end
    tick(3);
    rand_rdy = 1'b0;
    tick(1);
    ready = 1'b1;
    tick(5);
    chk("queue_drained", q.size(), 0);
    chk("frame_err_count", fe_seen, fe_exp);
    chk("parity_err_count", pe_seen, pe_exp);
    chk("end_valid", valid, 0);
    chk("end_overrun", overrun, 0);
    chk("end_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
